// File: rtl/ctrl_pkg.sv
// Shared definitions for the cpu_ctrl sequencer: opcodes, ALU op codes, FSM states, decode payload.
// The CALL/RET opcodes are only decoded when CTRL_CALL_STACK_EN is defined.
package ctrl_pkg;

    localparam logic [3:0] OPC_LDI  = 4'h8;
    localparam logic [3:0] OPC_STA  = 4'h9;
    localparam logic [3:0] OPC_JMP  = 4'hA;
    localparam logic [3:0] OPC_JC   = 4'hB;
    localparam logic [3:0] OPC_JNC  = 4'hC;
    localparam logic [3:0] OPC_HALT = 4'hD;
    localparam logic [3:0] OPC_CALL = 4'hE;
    localparam logic [3:0] OPC_RET  = 4'hF;

    // ALU op codes, shared with the ALU; ops above ALU_CMP leave carry untouched
    localparam logic [2:0] ALU_ADC  = 3'b000;
    localparam logic [2:0] ALU_SBC  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_CMP  = 3'b101;
    localparam logic [2:0] ALU_PASS = 3'b110;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        JK_NONE = 3'd0,
        JK_JMP  = 3'd1,
        JK_JC   = 3'd2,
        JK_JNC  = 3'd3,
        JK_HALT = 3'd4,
        JK_CALL = 3'd5,
        JK_RET  = 3'd6
    } jkind_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_ce_cy;
        logic       a_we;
        logic       rf_we;
        logic       r_sel_imm;
        jkind_t     kind;
    } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode for cpu_ctrl: strobes, operand select and program-flow kind.
// CALL/RET decode only when CTRL_CALL_STACK_EN is defined; otherwise they fall through as NOPs.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [3:0] i_opc,
    output dec_t       o_dec
);

    always_comb begin
        o_dec.alu_op    = 3'b000;
        o_dec.alu_ce_cy = 1'b0;
        o_dec.a_we      = 1'b0;
        o_dec.rf_we     = 1'b0;
        o_dec.r_sel_imm = 1'b0;
        o_dec.kind      = JK_NONE;

        // Low half of the opcode space is ALU A,R with the op taken directly from the opcode
        if (!i_opc[3]) begin
            o_dec.alu_op    = i_opc[2:0];
            o_dec.a_we      = 1'b1;
            o_dec.alu_ce_cy = (i_opc[2:0] <= ALU_CMP);
        end else begin
            case (i_opc)
                OPC_LDI: begin
                    o_dec.alu_op    = ALU_PASS;
                    o_dec.r_sel_imm = 1'b1;
                    o_dec.a_we      = 1'b1;
                end
                OPC_STA: begin
                    o_dec.alu_op = ALU_PASS;
                    o_dec.rf_we  = 1'b1;
                end
                OPC_JMP:  o_dec.kind = JK_JMP;
                OPC_JC:   o_dec.kind = JK_JC;
                OPC_JNC:  o_dec.kind = JK_JNC;
                OPC_HALT: o_dec.kind = JK_HALT;
`ifdef CTRL_CALL_STACK_EN
                OPC_CALL: o_dec.kind = JK_CALL;
                OPC_RET:  o_dec.kind = JK_RET;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Two-cycle FETCH/EXEC sequencer in front of the 8-bit ALU: owns the FSM, program counter and return stack.
// Define CTRL_CALL_STACK_EN to add the STACK_D-entry circular CALL/RET stack.
module cpu_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned RF_AW   = 3
`ifdef CTRL_CALL_STACK_EN
    ,
    parameter int unsigned STACK_D = 4
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic [PC_W-1:0]  pm_addr,
    input  logic [11:0]      pm_data,
    output logic [2:0]       alu_op,
    output logic             alu_ce_cy,
    input  logic             alu_cy,
    output logic [RF_AW-1:0] rf_addr,
    output logic             rf_we,
    output logic             a_we,
    output logic             r_sel_imm,
    output logic [7:0]       imm,
    output logic             halted
);

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_pc_nxt;
    logic            w_exec;
    dec_t            w_dec;

    ctrl_decode u_decode (
        .i_opc (pm_data[11:8]),
        .o_dec (w_dec)
    );

    assign w_exec   = (r_state == ST_EXEC);
    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_target = pm_data[PC_W-1:0];

`ifdef CTRL_CALL_STACK_EN
    localparam int unsigned SP_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

    logic [PC_W-1:0] r_stack [STACK_D];
    logic [SP_W-1:0] r_sp;
    logic [SP_W-1:0] w_sp_top;
    logic [PC_W-1:0] w_ret_pc;

    assign w_sp_top = r_sp - SP_W'(1);
    assign w_ret_pc = r_stack[w_sp_top];

    // Circular return stack: overflow overwrites the oldest slot, underflow reads a stale one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp <= '0;
            for (int i = 0; i < STACK_D; i++) begin
                r_stack[i] <= '0;
            end
        end else if (w_exec) begin
            if (w_dec.kind == JK_CALL) begin
                r_stack[r_sp] <= w_pc_inc;
                r_sp          <= r_sp + SP_W'(1);
            end else if (w_dec.kind == JK_RET) begin
                r_sp <= w_sp_top;
            end
        end
    end
`endif

    // Next pc, committed on the edge that leaves EXEC
    always_comb begin
        w_pc_nxt = w_pc_inc;
        case (w_dec.kind)
            JK_JMP:  w_pc_nxt = w_target;
            JK_JC:   if (alu_cy)  w_pc_nxt = w_target;
            JK_JNC:  if (!alu_cy) w_pc_nxt = w_target;
            JK_HALT: w_pc_nxt = r_pc;
`ifdef CTRL_CALL_STACK_EN
            JK_CALL: w_pc_nxt = w_target;
            JK_RET:  w_pc_nxt = w_ret_pc;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_pc    <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (run) r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_state <= (w_dec.kind == JK_HALT) ? ST_HALT : ST_FETCH;
                    r_pc    <= w_pc_nxt;
                end
                default: ;
            endcase
        end
    end

    // Everything except pm_addr/halted is forced low outside EXEC, so reset kills strobes at once
    assign pm_addr   = r_pc;
    assign halted    = (r_state == ST_HALT);
    assign alu_op    = w_exec ? w_dec.alu_op    : 3'b000;
    assign alu_ce_cy = w_exec ? w_dec.alu_ce_cy : 1'b0;
    assign a_we      = w_exec ? w_dec.a_we      : 1'b0;
    assign rf_we     = w_exec ? w_dec.rf_we     : 1'b0;
    assign r_sel_imm = w_exec ? w_dec.r_sel_imm : 1'b0;
    assign imm       = w_exec ? pm_data[7:0]    : 8'h00;
    assign rf_addr   = w_exec ? pm_data[RF_AW-1:0] : '0;

endmodule
